// File: rtl/load_store_queue.sv
// In-order load/store queue between dispatch/ROB and the memory controller's LSB port.
// Defining LSQ_PERF_CNT_EN adds the perf_loads/perf_stores completion counters.
module load_store_queue #(
    parameter int unsigned LSQ_SIZE  = 8,
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 roll_back,
    input  logic                 issue_en,
    input  logic                 issue_rw,
    input  logic [1:0]           issue_size,
    input  logic                 issue_signed,
    input  logic [31:0]          issue_addr,
    input  logic [31:0]          issue_data,
    input  logic [TAG_WIDTH-1:0] issue_tag,
    output logic                 full,
    input  logic                 commit_en,
    input  logic [TAG_WIDTH-1:0] commit_tag,
    output logic                 mem_rw,
    output logic [1:0]           mem_d_type,
    output logic [31:0]          mem_ain,
    output logic [31:0]          mem_din,
    input  logic                 mem_dout_en,
    input  logic [31:0]          mem_dout,
    input  logic                 mem_w_done,
    output logic                 ld_out_en,
    output logic [TAG_WIDTH-1:0] ld_out_tag,
    output logic [31:0]          ld_out_data,
    output logic                 st_done_en,
`ifdef LSQ_PERF_CNT_EN
    output logic [31:0]          perf_loads,
    output logic [31:0]          perf_stores,
`endif
    output logic [TAG_WIDTH-1:0] st_done_tag
);

    localparam int unsigned PW = $clog2(LSQ_SIZE);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StWaitLoad  = 2'd1;
    localparam logic [1:0] StWaitStore = 2'd2;

    logic                 ent_rw_q   [LSQ_SIZE];
    logic [1:0]           ent_size_q [LSQ_SIZE];
    logic                 ent_sgn_q  [LSQ_SIZE];
    logic [31:0]          ent_addr_q [LSQ_SIZE];
    logic [31:0]          ent_data_q [LSQ_SIZE];
    logic [TAG_WIDTH-1:0] ent_tag_q  [LSQ_SIZE];
    logic                 ent_cmt_q  [LSQ_SIZE];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;

    logic [PW-1:0]       off   [LSQ_SIZE];
    logic [PW-1:0]       pidx  [LSQ_SIZE];
    logic [LSQ_SIZE-1:0] valid;
    logic [LSQ_SIZE-1:0] cmt_d;
    logic [CW-1:0]       keep_cnt;
    logic                stop;
    logic                head_ready;
    logic                do_issue, do_enq, do_deq, ld_done, st_done;
    logic [31:0]         ld_ext;

    function automatic logic [31:0] extend(input logic [1:0] size, input logic sgn,
                                           input logic [31:0] raw);
        logic [31:0] res;
        case (size)
            2'b01:   res = {{24{sgn & raw[7]}}, raw[7:0]};
            2'b10:   res = {{16{sgn & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign full = (count_q == CW'(LSQ_SIZE));

    // Occupancy and commit marking; commit lands before any flush in the same cycle.
    always_comb begin
        valid = '0;
        cmt_d = '0;
        for (int i = 0; i < LSQ_SIZE; i++) begin
            off[i]   = PW'(i) - head_q;
            valid[i] = ({1'b0, off[i]} < count_q);
            cmt_d[i] = ent_cmt_q[i] | (commit_en && valid[i] && ent_rw_q[i] &&
                                       (ent_tag_q[i] == commit_tag));
        end
    end

    // Length of the committed-store run starting at head survives a flush.
    always_comb begin
        keep_cnt = '0;
        stop     = 1'b0;
        for (int k = 0; k < LSQ_SIZE; k++) begin
            pidx[k] = head_q + PW'(k);
            if (!stop && (CW'(k) < count_q) && cmt_d[pidx[k]]) begin
                keep_cnt = keep_cnt + CW'(1);
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_comb begin
        head_ready = (count_q != '0) && (!ent_rw_q[head_q] || ent_cmt_q[head_q]);
        do_issue   = (state_q == StIdle) && !roll_back && head_ready;
        ld_done    = (state_q == StWaitLoad) && mem_dout_en && !roll_back;
        st_done    = (state_q == StWaitStore) && mem_w_done;
        do_deq     = ld_done | st_done;
        do_enq     = issue_en && !full && !roll_back;
        ld_ext     = extend(ent_size_q[head_q], ent_sgn_q[head_q], mem_dout);

        head_d = head_q + PW'(do_deq);
        if (roll_back) begin
            tail_d  = head_q + keep_cnt[PW-1:0];
            count_d = keep_cnt - CW'(do_deq);
        end else begin
            tail_d  = tail_q + PW'(do_enq);
            count_d = count_q + CW'(do_enq) - CW'(do_deq);
        end

        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (do_issue) state_d = ent_rw_q[head_q] ? StWaitStore : StWaitLoad;
            end
            StWaitLoad: begin
                if (roll_back || mem_dout_en) state_d = StIdle;
            end
            StWaitStore: begin
                if (mem_w_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            mem_rw      <= 1'b0;
            mem_d_type  <= 2'b00;
            mem_ain     <= '0;
            mem_din     <= '0;
            ld_out_en   <= 1'b0;
            ld_out_tag  <= '0;
            ld_out_data <= '0;
            st_done_en  <= 1'b0;
            st_done_tag <= '0;
            for (int i = 0; i < LSQ_SIZE; i++) begin
                ent_rw_q[i]  <= 1'b0;
                ent_cmt_q[i] <= 1'b0;
            end
        end else if (rdy_in) begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            state_q    <= state_d;
            mem_d_type <= 2'b00;
            ld_out_en  <= 1'b0;
            st_done_en <= 1'b0;
            if (do_issue) begin
                mem_rw     <= ent_rw_q[head_q];
                mem_ain    <= ent_addr_q[head_q];
                mem_din    <= ent_data_q[head_q];
                mem_d_type <= ent_size_q[head_q];
            end
            if (ld_done) begin
                ld_out_en   <= 1'b1;
                ld_out_tag  <= ent_tag_q[head_q];
                ld_out_data <= ld_ext;
            end
            if (st_done) begin
                st_done_en  <= 1'b1;
                st_done_tag <= ent_tag_q[head_q];
            end
            for (int i = 0; i < LSQ_SIZE; i++) begin
                ent_cmt_q[i] <= cmt_d[i];
            end
            if (do_enq) begin
                ent_rw_q[tail_q]   <= issue_rw;
                ent_size_q[tail_q] <= issue_size;
                ent_sgn_q[tail_q]  <= issue_signed;
                ent_addr_q[tail_q] <= issue_addr;
                ent_data_q[tail_q] <= issue_data;
                ent_tag_q[tail_q]  <= issue_tag;
                ent_cmt_q[tail_q]  <= 1'b0;
            end
        end
    end

`ifdef LSQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst_in) begin
            perf_loads  <= '0;
            perf_stores <= '0;
        end else if (rdy_in) begin
            if (ld_done) perf_loads <= perf_loads + 32'd1;
            if (st_done) perf_stores <= perf_stores + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_load_store_queue.sv
// Directed self-checking bench for load_store_queue; the bench plays the memory controller.
module tb_load_store_queue;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        roll_back = 1'b0;
    logic        issue_en = 1'b0;
    logic        issue_rw = 1'b0;
    logic [1:0]  issue_size = 2'b00;
    logic        issue_signed = 1'b0;
    logic [31:0] issue_addr = '0;
    logic [31:0] issue_data = '0;
    logic [3:0]  issue_tag = '0;
    logic        full;
    logic        commit_en = 1'b0;
    logic [3:0]  commit_tag = '0;
    logic        mem_rw;
    logic [1:0]  mem_d_type;
    logic [31:0] mem_ain;
    logic [31:0] mem_din;
    logic        mem_dout_en = 1'b0;
    logic [31:0] mem_dout = '0;
    logic        mem_w_done = 1'b0;
    logic        ld_out_en;
    logic [3:0]  ld_out_tag;
    logic [31:0] ld_out_data;
    logic        st_done_en;
    logic [3:0]  st_done_tag;
`ifdef LSQ_PERF_CNT_EN
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;
`endif

    int vectors = 0;
    int miscompares = 0;

    load_store_queue #(.LSQ_SIZE(8), .TAG_WIDTH(4)) dut (
        .clk          (clk),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .roll_back    (roll_back),
        .issue_en     (issue_en),
        .issue_rw     (issue_rw),
        .issue_size   (issue_size),
        .issue_signed (issue_signed),
        .issue_addr   (issue_addr),
        .issue_data   (issue_data),
        .issue_tag    (issue_tag),
        .full         (full),
        .commit_en    (commit_en),
        .commit_tag   (commit_tag),
        .mem_rw       (mem_rw),
        .mem_d_type   (mem_d_type),
        .mem_ain      (mem_ain),
        .mem_din      (mem_din),
        .mem_dout_en  (mem_dout_en),
        .mem_dout     (mem_dout),
        .mem_w_done   (mem_w_done),
        .ld_out_en    (ld_out_en),
        .ld_out_tag   (ld_out_tag),
        .ld_out_data  (ld_out_data),
        .st_done_en   (st_done_en),
`ifdef LSQ_PERF_CNT_EN
        .perf_loads   (perf_loads),
        .perf_stores  (perf_stores),
`endif
        .st_done_tag  (st_done_tag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_op(input logic rw, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] tag);
        issue_rw = rw; issue_size = size; issue_signed = sgn;
        issue_addr = addr; issue_data = data; issue_tag = tag;
        issue_en = 1'b1;
        tick();
        issue_en = 1'b0;
    endtask

    task automatic wait_req(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (mem_d_type != 2'b00) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic serve_load(input logic [31:0] data);
        mem_dout = data; mem_dout_en = 1'b1;
        tick();
        mem_dout_en = 1'b0;
    endtask

    task automatic serve_store();
        mem_w_done = 1'b1;
        tick();
        mem_w_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick(); tick(); tick();
        rst_in = 1'b0;
        vectors++;
        if ({full, mem_rw, mem_d_type, ld_out_en, st_done_en} !== 6'b0) begin
            $display("FAIL reset_ctrl: got %b want 000000",
                     {full, mem_rw, mem_d_type, ld_out_en, st_done_en});
            miscompares++;
        end
        vectors++;
        if ({mem_ain, mem_din, ld_out_data, ld_out_tag, st_done_tag} !== '0) begin
            $display("FAIL reset_data: ain=%h din=%h ld=%h/%h st=%h want all 0",
                     mem_ain, mem_din, ld_out_tag, ld_out_data, st_done_tag);
            miscompares++;
        end
    endtask

    task automatic test_load_byte();
        bit got;
        issue_op(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 4'd3);
        wait_req(8, got);
        vectors++;
        if (!got || mem_d_type !== 2'b01 || mem_ain !== 32'h100 || mem_rw !== 1'b0) begin
            $display("FAIL lb_req: got=%0d type=%b ain=%h rw=%b want 1 01 00000100 0",
                     got, mem_d_type, mem_ain, mem_rw);
            miscompares++;
        end
        tick();
        vectors++;
        if (mem_d_type !== 2'b00) begin
            $display("FAIL lb_pulse: d_type=%b want 00", mem_d_type);
            miscompares++;
        end
        serve_load(32'h0000_00F0);
        vectors++;
        if (ld_out_en !== 1'b1 || ld_out_tag !== 4'd3 || ld_out_data !== 32'hFFFF_FFF0) begin
            $display("FAIL lb_result: en=%b tag=%0d data=%h want 1 3 fffffff0",
                     ld_out_en, ld_out_tag, ld_out_data);
            miscompares++;
        end
        tick();
        vectors++;
        if (ld_out_en !== 1'b0) begin
            $display("FAIL lb_result_clear: en=%b want 0", ld_out_en);
            miscompares++;
        end
    endtask

    task automatic test_store_commit();
        bit got;
        int early = 0;
        issue_op(1'b1, 2'b11, 1'b0, 32'h200, 32'hDEAD_BEEF, 4'd5);
        for (int i = 0; i < 10; i++) begin
            if (mem_d_type !== 2'b00) early++;
            tick();
        end
        vectors++;
        if (early != 0) begin
            $display("FAIL sw_precommit: %0d request cycles before commit, want 0", early);
            miscompares++;
        end
        commit_en = 1'b1; commit_tag = 4'd5;
        tick();
        commit_en = 1'b0;
        wait_req(8, got);
        vectors++;
        if (!got || mem_rw !== 1'b1 || mem_d_type !== 2'b11 || mem_ain !== 32'h200 ||
            mem_din !== 32'hDEAD_BEEF) begin
            $display("FAIL sw_req: got=%0d rw=%b type=%b ain=%h din=%h want 1 1 11 200 deadbeef",
                     got, mem_rw, mem_d_type, mem_ain, mem_din);
            miscompares++;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (mem_din !== 32'hDEAD_BEEF || mem_rw !== 1'b1 || mem_d_type !== 2'b00) begin
                $display("FAIL sw_hold: din=%h rw=%b type=%b want deadbeef 1 00",
                         mem_din, mem_rw, mem_d_type);
                miscompares++;
            end
        end
        serve_store();
        vectors++;
        if (st_done_en !== 1'b1 || st_done_tag !== 4'd5) begin
            $display("FAIL sw_done: en=%b tag=%0d want 1 5", st_done_en, st_done_tag);
            miscompares++;
        end
        tick();
        vectors++;
        if (st_done_en !== 1'b0) begin
            $display("FAIL sw_done_clear: en=%b want 0", st_done_en);
            miscompares++;
        end
    endtask

    task automatic test_full();
        bit got;
        int seq [8] = '{2, 3, 4, 5, 6, 7, 10, 11};
        int stray = 0;
        for (int t = 0; t < 8; t++) begin
            issue_op(1'b0, 2'b10, 1'b0, 32'h300 + 32'(2 * t), 32'h0, 4'(t));
        end
        vectors++;
        if (full !== 1'b1) begin
            $display("FAIL full_set: full=%b want 1", full);
            miscompares++;
        end
        issue_op(1'b0, 2'b10, 1'b0, 32'h312, 32'h0, 4'd9);
        vectors++;
        if (full !== 1'b1 || mem_ain !== 32'h300) begin
            $display("FAIL full_hold: full=%b ain=%h want 1 00000300", full, mem_ain);
            miscompares++;
        end
        serve_load(32'h0000_8001);
        vectors++;
        if (ld_out_en !== 1'b1 || ld_out_tag !== 4'd0 || ld_out_data !== 32'h0000_8001 ||
            full !== 1'b0) begin
            $display("FAIL lhu_first: en=%b tag=%0d data=%h full=%b want 1 0 00008001 0",
                     ld_out_en, ld_out_tag, ld_out_data, full);
            miscompares++;
        end
        wait_req(8, got);
        // Enqueue tag 10 in the same cycle tag 1 completes.
        issue_rw = 1'b0; issue_size = 2'b10; issue_signed = 1'b0;
        issue_addr = 32'h314; issue_tag = 4'd10; issue_en = 1'b1;
        mem_dout = 32'h0000_8011; mem_dout_en = 1'b1;
        tick();
        issue_en = 1'b0; mem_dout_en = 1'b0;
        vectors++;
        if (!got || ld_out_tag !== 4'd1 || ld_out_data !== 32'h0000_8011 || full !== 1'b0) begin
            $display("FAIL enq_deq: got=%0d tag=%0d data=%h full=%b want 1 1 00008011 0",
                     got, ld_out_tag, ld_out_data, full);
            miscompares++;
        end
        issue_op(1'b0, 2'b10, 1'b0, 32'h316, 32'h0, 4'd11);
        vectors++;
        if (full !== 1'b1) begin
            $display("FAIL refill: full=%b want 1", full);
            miscompares++;
        end
        for (int n = 0; n < 8; n++) begin
            logic [31:0] d;
            d = 32'h0000_8001 + 32'(seq[n] << 4);
            wait_req(8, got);
            vectors++;
            if (!got || mem_ain !== 32'h300 + 32'(2 * seq[n])) begin
                $display("FAIL drain_req: got=%0d ain=%h want 1 %h",
                         got, mem_ain, 32'h300 + 32'(2 * seq[n]));
                miscompares++;
            end
            serve_load(d);
            vectors++;
            if (ld_out_en !== 1'b1 || ld_out_tag !== 4'(seq[n]) || ld_out_data !== d) begin
                $display("FAIL drain_result: en=%b tag=%0d data=%h want 1 %0d %h",
                         ld_out_en, ld_out_tag, ld_out_data, seq[n], d);
                miscompares++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            if (mem_d_type !== 2'b00) stray++;
            tick();
        end
        vectors++;
        if (stray != 0) begin
            $display("FAIL ninth_ignored: %0d extra request cycles, want 0", stray);
            miscompares++;
        end
    endtask

    task automatic test_rollback_store();
        bit got;
        int stray = 0;
        issue_op(1'b1, 2'b01, 1'b0, 32'h400, 32'h55, 4'd1);
        commit_en = 1'b1; commit_tag = 4'd1;
        issue_op(1'b1, 2'b11, 1'b0, 32'h404, 32'h66, 4'd2);
        commit_en = 1'b0;
        issue_op(1'b0, 2'b11, 1'b0, 32'h408, 32'h0, 4'd3);
        wait_req(8, got);
        vectors++;
        if (!got || mem_ain !== 32'h400 || mem_rw !== 1'b1 || mem_d_type !== 2'b01) begin
            $display("FAIL rb_sb_req: got=%0d ain=%h rw=%b type=%b want 1 400 1 01",
                     got, mem_ain, mem_rw, mem_d_type);
            miscompares++;
        end
        tick();
        roll_back = 1'b1;
        tick();
        roll_back = 1'b0;
        tick();
        serve_store();
        vectors++;
        if (st_done_en !== 1'b1 || st_done_tag !== 4'd1) begin
            $display("FAIL rb_sb_done: en=%b tag=%0d want 1 1", st_done_en, st_done_tag);
            miscompares++;
        end
        for (int i = 0; i < 12; i++) begin
            if (mem_d_type !== 2'b00 || ld_out_en !== 1'b0) stray++;
            tick();
        end
        vectors++;
        if (stray != 0 || full !== 1'b0) begin
            $display("FAIL rb_flushed: %0d stray cycles full=%b want 0 0", stray, full);
            miscompares++;
        end
    endtask

    task automatic test_rollback_load();
        bit got;
        issue_op(1'b0, 2'b11, 1'b0, 32'h500, 32'h0, 4'd6);
        wait_req(8, got);
        vectors++;
        if (!got || mem_ain !== 32'h500) begin
            $display("FAIL rbl_req: got=%0d ain=%h want 1 00000500", got, mem_ain);
            miscompares++;
        end
        tick();
        roll_back = 1'b1;
        tick();
        roll_back = 1'b0;
        vectors++;
        if (mem_d_type !== 2'b00 || ld_out_en !== 1'b0) begin
            $display("FAIL rbl_abort: type=%b en=%b want 00 0", mem_d_type, ld_out_en);
            miscompares++;
        end
        tick(); tick();
        serve_load(32'h1234_5678);
        vectors++;
        if (ld_out_en !== 1'b0 || mem_d_type !== 2'b00) begin
            $display("FAIL rbl_stale: en=%b type=%b want 0 00", ld_out_en, mem_d_type);
            miscompares++;
        end
        issue_op(1'b0, 2'b11, 1'b0, 32'h600, 32'h0, 4'd7);
        wait_req(8, got);
        vectors++;
        if (!got || mem_ain !== 32'h600 || mem_d_type !== 2'b11) begin
            $display("FAIL rbl_next_req: got=%0d ain=%h type=%b want 1 600 11",
                     got, mem_ain, mem_d_type);
            miscompares++;
        end
        serve_load(32'hCAFE_F00D);
        vectors++;
        if (ld_out_en !== 1'b1 || ld_out_tag !== 4'd7 || ld_out_data !== 32'hCAFE_F00D) begin
            $display("FAIL rbl_next_result: en=%b tag=%0d data=%h want 1 7 cafef00d",
                     ld_out_en, ld_out_tag, ld_out_data);
            miscompares++;
        end
    endtask

    task automatic test_extend();
        bit got;
        issue_op(1'b0, 2'b10, 1'b1, 32'h800, 32'h0, 4'd12);
        issue_op(1'b0, 2'b01, 1'b0, 32'h804, 32'h0, 4'd13);
        wait_req(8, got);
        serve_load(32'h0000_8001);
        vectors++;
        if (!got || ld_out_tag !== 4'd12 || ld_out_data !== 32'hFFFF_8001) begin
            $display("FAIL lh_signed: got=%0d tag=%0d data=%h want 1 12 ffff8001",
                     got, ld_out_tag, ld_out_data);
            miscompares++;
        end
        wait_req(8, got);
        serve_load(32'h0000_00F0);
        vectors++;
        if (!got || ld_out_tag !== 4'd13 || ld_out_data !== 32'h0000_00F0) begin
            $display("FAIL lbu: got=%0d tag=%0d data=%h want 1 13 000000f0",
                     got, ld_out_tag, ld_out_data);
            miscompares++;
        end
    endtask

    task automatic test_rdy_pause();
        bit got;
        int moved = 0;
        issue_op(1'b1, 2'b10, 1'b0, 32'h700, 32'h0000_BEEF, 4'd8);
        commit_en = 1'b1; commit_tag = 4'd8;
        tick();
        commit_en = 1'b0;
        wait_req(8, got);
        vectors++;
        if (!got || mem_ain !== 32'h700 || mem_din !== 32'h0000_BEEF) begin
            $display("FAIL rdy_req: got=%0d ain=%h din=%h want 1 700 0000beef",
                     got, mem_ain, mem_din);
            miscompares++;
        end
        tick();
        rdy_in = 1'b0; mem_w_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (st_done_en !== 1'b0 || mem_ain !== 32'h700 || mem_d_type !== 2'b00) moved++;
        end
        vectors++;
        if (moved != 0) begin
            $display("FAIL rdy_hold: %0d cycles advanced while paused, want 0", moved);
            miscompares++;
        end
`ifdef LSQ_PERF_CNT_EN
        vectors++;
        if (perf_stores !== 32'd2) begin
            $display("FAIL perf_paused: perf_stores=%0d want 2", perf_stores);
            miscompares++;
        end
`endif
        rdy_in = 1'b1;
        tick();
        mem_w_done = 1'b0;
        vectors++;
        if (st_done_en !== 1'b1 || st_done_tag !== 4'd8) begin
            $display("FAIL rdy_done: en=%b tag=%0d want 1 8", st_done_en, st_done_tag);
            miscompares++;
        end
        tick();
        vectors++;
        if (st_done_en !== 1'b0) begin
            $display("FAIL rdy_done_clear: en=%b want 0", st_done_en);
            miscompares++;
        end
`ifdef LSQ_PERF_CNT_EN
        vectors++;
        if (perf_stores !== 32'd3 || perf_loads !== 32'd14) begin
            $display("FAIL perf_counts: stores=%0d loads=%0d want 3 14",
                     perf_stores, perf_loads);
            miscompares++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_commit();
        test_full();
        test_rollback_store();
        test_rollback_load();
        test_extend();
        test_rdy_pause();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
